// File: rtl/mdio_pkg.sv
// mdio_pkg: state encoding, frame constants and field widths for the MDIO master
package mdio_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_TA, S_DATA} state_t;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;
    localparam int PHY_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 16;
endpackage

// File: rtl/mdio_shift_reg.sv
// mdio_shift_reg: 32-bit loadable MSB-first shift register with serial input
//   clk, reset : clock and asynchronous active-high reset
//   load       : parallel load of load_val (wins over shift)
//   shift      : shift left by one, sin enters at bit 0
//   msb, nxt   : current and next bit to be sent
//   low        : lower 16 bits, holds the received word after 16 shifts
module mdio_shift_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        shift,
    input  logic        sin,
    output logic        msb,
    output logic        nxt,
    output logic [15:0] low
);
    logic [31:0] q;
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (load) q <= load_val;
        else if (shift) q <= {q[30:0], sin};
    assign msb = q[31];
    assign nxt = q[30];
    assign low = q[15:0];
endmodule

// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO frame engine driving MDC/MDIO from a clk_en half-period strobe
//   clk, reset            : system clock, asynchronous active-high reset
//   clk_en                : one pulse per MDC half-period
//   start, op_read,
//   phy_addr, reg_addr,
//   wdata                 : request, sampled only when idle
//   busy, done, rdata     : status, completion pulse, read data
//   ack_err               : read with no PHY answering in TA (MDIO_READ_ACK_CHECK_EN)
//   mdc, mdio_o, mdio_oe,
//   mdio_i                : pad-side management clock and tri-state data
module mdio_master
    import mdio_pkg::*;
#(
    parameter int PREAMBLE_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic              op_read,
    input  logic [PHY_W-1:0]  phy_addr,
    input  logic [REG_W-1:0]  reg_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              ack_err,
    output logic              mdc,
    output logic              mdio_o,
    output logic              mdio_oe,
    input  logic              mdio_i
);
    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BITS - 1);
    state_t state, state_n;
    logic [5:0] cnt, cnt_n;
    logic mdc_n, mdio_o_n, oe_n, done_n, op_rd, op_rd_n, bit_last;
    logic sr_load, sr_shift, sr_in, sr_msb, sr_nxt;
    logic [15:0] sr_low;

    mdio_shift_reg u_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (sr_load),
        .load_val ({ST, op_read ? OP_READ : OP_WRITE, phy_addr, reg_addr, TA_WRITE, wdata}),
        .shift    (sr_shift),
        .sin      (sr_in),
        .msb      (sr_msb),
        .nxt      (sr_nxt),
        .low      (sr_low)
    );

    assign busy = state != S_IDLE;
    assign bit_last = cnt == (state == S_PREAMBLE ? PRE_LAST : state == S_HEADER ? 6'd13 :
                              state == S_TA ? 6'd1 : 6'd15);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mdc     <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
            done    <= 1'b0;
            op_rd   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mdc     <= mdc_n;
            mdio_o  <= mdio_o_n;
            mdio_oe <= oe_n;
            done    <= done_n;
            op_rd   <= op_rd_n;
        end

    // Transmit shifts on falling edges; a read's DATA phase instead shifts mdio_i in on rising edges.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mdc_n    = mdc;
        mdio_o_n = mdio_o;
        oe_n     = mdio_oe;
        done_n   = 1'b0;
        op_rd_n  = op_rd;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_in    = 1'b0;
        if (state == S_IDLE) begin
            if (start) begin
                state_n  = S_PREAMBLE;
                cnt_n    = '0;
                mdio_o_n = 1'b1;
                oe_n     = 1'b1;
                op_rd_n  = op_read;
                sr_load  = 1'b1;
            end
        end else if (clk_en && !mdc) begin
            mdc_n    = 1'b1;
            sr_shift = op_rd && state == S_DATA;
            sr_in    = mdio_i;
        end else if (clk_en) begin
            mdc_n    = 1'b0;
            state_n  = !bit_last ? state : state == S_DATA ? S_IDLE : state_t'(state + 3'd1);
            cnt_n    = bit_last ? '0 : cnt + 6'd1;
            sr_shift = state != S_PREAMBLE && !(op_rd && state == S_DATA);
            done_n   = state == S_DATA && bit_last;
            mdio_o_n = (done_n || (state == S_PREAMBLE && !bit_last)) ? 1'b1 :
                       state == S_PREAMBLE ? sr_msb : sr_nxt;
            oe_n     = !done_n && !(op_rd && state_n == S_TA) && mdio_oe;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) rdata <= '0;
        else if (done_n && op_rd) rdata <= sr_low;

`ifdef MDIO_READ_ACK_CHECK_EN
    logic ta_ack;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ta_ack  <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            if (clk_en && !mdc && state == S_TA && cnt == 6'd1) ta_ack <= mdio_i;
            if (done_n) ack_err <= op_rd && ta_ack;
        end
`else
    assign ack_err = 1'b0;
`endif
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed self-checking bench for mdio_master (32-bit and 1-bit preamble builds)
module tb_mdio_master;
    localparam int P = 32;
`ifdef MDIO_READ_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, start = 1'b0, start1 = 1'b0;
    logic op_read = 1'b0, mdio_i = 1'b1;
    logic [4:0] phy_addr = '0, reg_addr = '0;
    logic [15:0] wdata = '0;
    logic busy, done, ack_err, mdc, mdio_o, mdio_oe;
    logic [15:0] rdata;
    logic busy1, done1, ack_err1, mdc1, mdio_o1, mdio_oe1;
    logic [15:0] rdata1;

    int checks = 0, errors = 0;
    int div = 0;
    int done_cnt = 0, en_cnt = 0, lat = 0, ncap = 0;
    logic [63:0] cap_o = '0, cap_oe = '0;
    logic [3:0] done_out = '0;
    logic busy_d = 1'b0, mdc_d = 1'b0;
    bit phy_mode = 1'b0;
    logic [15:0] phy_data = '0;
    int done1_cnt = 0, en1_cnt = 0, lat1 = 0, ncap1 = 0;
    logic [32:0] cap1 = '0;
    logic busy1_d = 1'b0, mdc1_d = 1'b0;

    always #5 clk = ~clk;
    always @(negedge clk) begin
        div = (div + 1) % 4;
        clk_en = div == 0;
    end

    mdio_master u_dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .op_read(op_read),
        .phy_addr(phy_addr), .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .ack_err(ack_err), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .mdio_i(mdio_i)
    );

    mdio_master #(.PREAMBLE_BITS(1)) u_p1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start1), .op_read(op_read),
        .phy_addr(phy_addr), .reg_addr(reg_addr), .wdata(wdata), .busy(busy1), .done(done1),
        .rdata(rdata1), .ack_err(ack_err1), .mdc(mdc1), .mdio_o(mdio_o1), .mdio_oe(mdio_oe1),
        .mdio_i(mdio_i)
    );

    // PHY model: value the PHY presents during frame bit k of a read
    function automatic logic phy_bit(input int k);
        if (k == P + 15) return 1'b0;
        if (k >= P + 16 && k < P + 32) return phy_data[4'(P + 31 - k)];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        #1;
        if (busy && !busy_d) en_cnt = 0;
        else if (clk_en) en_cnt++;
        if (mdc && !mdc_d) begin
            cap_o = {cap_o[62:0], mdio_o};
            cap_oe = {cap_oe[62:0], mdio_oe};
            ncap++;
        end
        if (!mdc && mdc_d && phy_mode) mdio_i = phy_bit(ncap);
        if (done) begin
            done_cnt++;
            lat = en_cnt;
            done_out = {mdc, mdio_o, mdio_oe, busy};
        end
        busy_d = busy;
        mdc_d = mdc;
        if (busy1 && !busy1_d) en1_cnt = 0;
        else if (clk_en) en1_cnt++;
        if (mdc1 && !mdc1_d) begin
            cap1 = {cap1[31:0], mdio_o1};
            ncap1++;
        end
        if (done1) begin
            done1_cnt++;
            lat1 = en1_cnt;
        end
        busy1_d = busy1;
        mdc1_d = mdc1;
    end

    task automatic do_start(input bit sel, input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd);
        @(negedge clk);
        op_read = rd;
        phy_addr = pa;
        reg_addr = ra;
        wdata = wd;
        if (sel) start1 = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (sel ? done1_cnt : done_cnt) > base;
        end
    endtask

    task automatic clear_cap();
        ncap = 0;
        cap_o = '0;
        cap_oe = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status got %b want 00", {busy, done});
        end
        checks++;
        if ({rdata, ack_err} !== 17'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%b want 0000/0", rdata, ack_err);
        end
        checks++;
        if ({mdc, mdio_o, mdio_oe} !== 3'b010) begin
            errors++;
            $display("FAIL reset_pins got %b want 010", {mdc, mdio_o, mdio_oe});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int base;
        bit ok;
        base = done_cnt;
        clear_cap();
        do_start(1'b0, 1'b0, 5'h01, 5'h00, 16'h1200);
        checks++;
        if ({busy, mdio_oe, mdio_o, mdc} !== 4'b1110) begin
            errors++;
            $display("FAIL accept_state got %b want 1110", {busy, mdio_oe, mdio_o, mdc});
        end
        wait_done(1'b0, base, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_timeout got no done want done");
        end
        checks++;
        if (cap_o !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1200}) begin
            errors++;
            $display("FAIL write_bits got %h want %h", cap_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1200});
        end
        checks++;
        if (cap_oe !== {64{1'b1}} || ncap !== 64) begin
            errors++;
            $display("FAIL write_oe got %h/%0d want ffffffffffffffff/64", cap_oe, ncap);
        end
        checks++;
        if (lat !== 128) begin
            errors++;
            $display("FAIL write_latency got %0d want 128", lat);
        end
        checks++;
        if (done_out !== 4'b0100) begin
            errors++;
            $display("FAIL done_pins got %b want 0100", done_out);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== base + 1 || rdata !== 16'h0) begin
            errors++;
            $display("FAIL write_single_done got %0d/%h want %0d/0000", done_cnt, rdata, base + 1);
        end
    endtask

    task automatic test_read(input bit phy_on, input logic [15:0] data);
        int base;
        bit ok;
        base = done_cnt;
        clear_cap();
        phy_data = data;
        phy_mode = phy_on;
        mdio_i = 1'b1;
        do_start(1'b0, 1'b1, 5'h03, 5'h02, 16'h5A5A);
        wait_done(1'b0, base, ok);
        phy_mode = 1'b0;
        mdio_i = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL read%0d_timeout got no done want done", phy_on);
        end
        checks++;
        if (cap_o[63:18] !== {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, 5'h02}) begin
            errors++;
            $display("FAIL read%0d_header got %h want %h", phy_on, cap_o[63:18], {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, 5'h02});
        end
        checks++;
        if (cap_oe !== {{46{1'b1}}, {18{1'b0}}}) begin
            errors++;
            $display("FAIL read%0d_oe got %h want %h", phy_on, cap_oe, {{46{1'b1}}, {18{1'b0}}});
        end
        checks++;
        if (rdata !== (phy_on ? data : 16'hFFFF)) begin
            errors++;
            $display("FAIL read%0d_rdata got %h want %h", phy_on, rdata, phy_on ? data : 16'hFFFF);
        end
        checks++;
        if (ack_err !== (phy_on ? 1'b0 : ACK_EN)) begin
            errors++;
            $display("FAIL read%0d_ack got %b want %b", phy_on, ack_err, phy_on ? 1'b0 : ACK_EN);
        end
        checks++;
        if (lat !== 128) begin
            errors++;
            $display("FAIL read%0d_latency got %0d want 128", phy_on, lat);
        end
    endtask

    task automatic test_busy_start();
        int base;
        bit ok;
        base = done_cnt;
        clear_cap();
        do_start(1'b0, 1'b0, 5'h0A, 5'h15, 16'hA5C3);
        repeat (80) @(negedge clk);
        do_start(1'b0, 1'b1, 5'h1F, 5'h1F, 16'h0000);
        wait_done(1'b0, base, ok);
        checks++;
        if (!ok || cap_o !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h0A, 5'h15, 2'b10, 16'hA5C3}) begin
            errors++;
            $display("FAIL busy_start_bits got %h want %h", cap_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h0A, 5'h15, 2'b10, 16'hA5C3});
        end
        repeat (700) @(negedge clk);
        checks++;
        if (done_cnt !== base + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_dones got %0d/%b want %0d/0", done_cnt, busy, base + 1);
        end
        checks++;
        if (rdata !== 16'hFFFF || ack_err !== 1'b0) begin
            errors++;
            $display("FAIL write_keeps_rdata got %h/%b want ffff/0", rdata, ack_err);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        base = done_cnt;
        clear_cap();
        phy_data = 16'h0141;
        phy_mode = 1'b1;
        do_start(1'b0, 1'b1, 5'h03, 5'h02, 16'h0000);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = ncap > 40;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_reach got %0d bits want 41", ncap);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if ({mdc, mdio_oe, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_abort got %b want 0000", {mdc, mdio_oe, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        phy_mode = 1'b0;
        mdio_i = 1'b1;
        repeat (700) @(negedge clk);
        checks++;
        if (done_cnt !== base) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d want %0d", done_cnt, base);
        end
        clear_cap();
        do_start(1'b0, 1'b0, 5'h01, 5'h00, 16'h1200);
        wait_done(1'b0, base, ok);
        checks++;
        if (!ok || cap_o !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1200} || rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_recover got %h/%h want %h/0000", cap_o, rdata, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1200});
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        base = done_cnt;
        clear_cap();
        phy_data = 16'h0141;
        phy_mode = 1'b1;
        do_start(1'b0, 1'b1, 5'h03, 5'h02, 16'h0000);
        wait_done(1'b0, base, ok);
        phy_mode = 1'b0;
        mdio_i = 1'b1;
        checks++;
        if (!ok || rdata !== 16'h0141) begin
            errors++;
            $display("FAIL b2b_read got %h want 0141", rdata);
        end
        clear_cap();
        do_start(1'b0, 1'b0, 5'h1F, 5'h1F, 16'hBEEF);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got %b want 1", busy);
        end
        wait_done(1'b0, base + 1, ok);
        checks++;
        if (!ok || cap_o !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h1F, 5'h1F, 2'b10, 16'hBEEF}) begin
            errors++;
            $display("FAIL b2b_write_bits got %h want %h", cap_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h1F, 5'h1F, 2'b10, 16'hBEEF});
        end
        checks++;
        if (rdata !== 16'h0141 || done_cnt !== base + 2) begin
            errors++;
            $display("FAIL b2b_final got %h/%0d want 0141/%0d", rdata, done_cnt, base + 2);
        end
    endtask

    task automatic test_short_preamble();
        int base;
        bit ok;
        base = done1_cnt;
        ncap1 = 0;
        cap1 = '0;
        do_start(1'b1, 1'b0, 5'h01, 5'h00, 16'h1200);
        wait_done(1'b1, base, ok);
        checks++;
        if (!ok || cap1 !== {1'b1, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1200} || ncap1 !== 33) begin
            errors++;
            $display("FAIL p1_bits got %h/%0d want %h/33", cap1, ncap1, {1'b1, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1200});
        end
        checks++;
        if (lat1 !== 66) begin
            errors++;
            $display("FAIL p1_latency got %0d want 66", lat1);
        end
        checks++;
        if ({busy1, mdio_oe1, rdata1, ack_err1, busy} !== 20'h0) begin
            errors++;
            $display("FAIL p1_idle got %b/%b/%h/%b/%b want 0/0/0000/0/0", busy1, mdio_oe1, rdata1, ack_err1, busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read(1'b1, 16'h0141);
        test_read(1'b0, 16'h0000);
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_short_preamble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
